mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have port CLK  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports dREN in 1, dWEN in 1, daddr in 32, dstore in 32  dcache request, held until completion.
REQ-004 SHALL have ports dwait out 1, dload out 32  dcache response; dwait=0 marks completion cycle.
REQ-005 SHALL have ports iREN in 1, iaddr in 32  icache read request, held until completion.
REQ-006 SHALL have ports iwait out 1, iload out 32  icache response; iwait=0 marks completion cycle.
REQ-007 SHALL have ports ramREN out 1, ramWEN out 1, ramaddr out 32, ramstore out 32  backing-RAM request.
REQ-008 SHALL have ports ramload in 32, ramready in 1  RAM read data; ramready=1 means the driven access completes this cycle.
REQ-009 SHALL have ports dcount out 16, icount out 16  completed data / instruction transaction counters.

Function
REQ-010 SHALL implement states IDLE, DSERV, ISERV, DLOCK; one RAM access outstanding at most.
REQ-011 SHALL in IDLE/DLOCK drive dwait=1, iwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, dload=0, iload=0.
REQ-012 SHALL in IDLE: if (dREN|dWEN) and not (lastd=1 and iREN) -> DSERV; else if iREN -> ISERV; else stay.
REQ-013 SHALL keep 1-bit lastd: set on data completion, cleared on instruction completion (round-robin fairness).
REQ-014 SHALL in DSERV drive ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN (write wins if both set).
REQ-015 SHALL in DSERV with ramready=1: dwait=0, dload=ramload (reads; 0 on writes) same cycle; dcount+1; next DLOCK if daddr[2]=0 else IDLE.
REQ-016 SHALL in DLOCK: if dREN|dWEN -> DSERV regardless of iREN (two-word block stays atomic); else -> IDLE; DLOCK lasts exactly one cycle.
REQ-017 SHALL in ISERV drive ramREN=1, ramWEN=0, ramaddr=iaddr; ramready=1 -> iwait=0, iload=ramload, icount+1, next IDLE.
REQ-018 SHALL keep dwait=1 and iwait=1 in every cycle other than the respective completion cycle; the non-served side always waits.
REQ-019 SHALL abort a serve state to IDLE, with no completion and no count increment, if the served request drops (dREN=dWEN=0 in DSERV, iREN=0 in ISERV) before ramready.
REQ-020 SHALL give minimum latency of 2 cycles: request sampled in IDLE at cycle N, completion earliest at N+1 when ramready=1 at N+1.
REQ-021 SHALL wrap dcount/icount modulo 2^16 (0xFFFF+1 -> 0x0000), no saturation.
REQ-022 SHALL leave lastd unchanged on abort.

Reset
REQ-023 SHALL, on RST=1 at a rising edge, set state=IDLE, lastd=0, dcount=0, icount=0; outputs per REQ-011 next cycle.
REQ-024 SHALL abandon any in-flight access on reset mid-operation; no completion pulse is produced for it.

Verification
REQ-025 Data read: dREN=1, daddr=0x00000040, ramready=1 one cycle after entry, ramload=0xDEADBEEF -> dwait=0 for one cycle, dload=0xDEADBEEF, dcount=1, state DLOCK.
REQ-026 Block lock: data 0x40 completes, iREN=1 and dREN=1 daddr=0x44 held -> 0x44 served before icache; then iaddr served; icount=1, dcount=2.
REQ-027 Fairness: dREN and iREN both held continuously, daddr[2]=1, ramready=1 -> grants alternate D, I, D, I; neither starves.
REQ-028 Write with ramready delayed 3 cycles: dWEN=1, daddr=0x3100, dstore=0x12345678 -> ramWEN=1, ramaddr=0x3100, ramstore=0x12345678 for 4 cycles, dwait=0 only in the 4th.
REQ-029 Abort/reset: iREN dropped in ISERV before ramready -> IDLE, icount unchanged; RST=1 during DSERV -> IDLE, counters 0, no dwait=0 pulse.
REQ-030 Wrap: preload dcount to 0xFFFF via 65535 completions -> next data completion gives dcount=0x0000.

Source files
------------

// File: rtl/mem_responder_if.sv
// mem_responder_if: dcache/icache request-response and backing-RAM signals for the memory responder.
interface mem_responder_if;
    logic        dREN, dWEN, dwait, iREN, iwait, ramREN, ramWEN, ramready;
    logic [31:0] daddr, dstore, dload, iaddr, iload, ramaddr, ramstore, ramload;
    logic [15:0] dcount, icount;
    modport slave (
        input  dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramready,
        output dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore, dcount, icount
    );
    modport master (
        output dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramready,
        input  dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore, dcount, icount
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: arbitrates dcache and icache onto one backing RAM, one access at a time,
// round-robin between the two sides with two-word data blocks kept atomic.
module mem_responder (
    input logic            CLK,
    input logic            RST,
    mem_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DSERV, ISERV, DLOCK} state_t;
    state_t      state, next_state;
    logic        lastd, d_done, i_done, dreq;
    logic [15:0] dcount, icount;
    assign dreq       = bus.dREN | bus.dWEN;
    assign bus.dcount = dcount;
    assign bus.icount = icount;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            lastd  <= 1'b0;
            dcount <= '0;
            icount <= '0;
        end else begin
            state <= next_state;
            if (d_done) begin
                dcount <= dcount + 16'd1;
                lastd  <= 1'b1;
            end
            if (i_done) begin
                icount <= icount + 16'd1;
                lastd  <= 1'b0;
            end
        end
    end
    always_comb begin
        next_state   = state;
        d_done       = 1'b0;
        i_done       = 1'b0;
        bus.dwait    = 1'b1;
        bus.iwait    = 1'b1;
        bus.dload    = '0;
        bus.iload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        case (state)
            IDLE: next_state = (dreq && !(lastd && bus.iREN)) ? DSERV : bus.iREN ? ISERV : IDLE;
            DSERV: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                d_done       = dreq & bus.ramready;
                bus.dwait    = ~d_done;
                bus.dload    = (d_done && !bus.dWEN) ? bus.ramload : '0;
                // an even word opens a two-word block, so hold the RAM for its partner
                next_state   = !dreq ? IDLE : !bus.ramready ? DSERV : bus.daddr[2] ? IDLE : DLOCK;
            end
            ISERV: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
                i_done      = bus.iREN & bus.ramready;
                bus.iwait   = ~i_done;
                bus.iload   = i_done ? bus.ramload : '0;
                next_state  = (!bus.iREN || bus.ramready) ? IDLE : ISERV;
            end
            DLOCK: next_state = dreq ? DSERV : IDLE;
            default: next_state = IDLE;
        endcase
    end
endmodule
